// File: rtl/calendar_set_ctrl_pkg.sv
// Shared types and date helpers for the calendar set controller.
// The DATE_CHECK_EN build uses days_in_month to validate UART frames.
package calendar_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_EDIT_DAY   = 3'd1,
        ST_EDIT_MONTH = 3'd2,
        ST_EDIT_YEAR  = 3'd3,
        ST_LOAD       = 3'd4
    } ctrl_state_e;

    localparam logic [1:0] FIELD_NONE  = 2'd0;
    localparam logic [1:0] FIELD_DAY   = 2'd1;
    localparam logic [1:0] FIELD_MONTH = 2'd2;
    localparam logic [1:0] FIELD_YEAR  = 2'd3;

    // Calendar reset date is 2/2/24.
    localparam logic [6:0] RESET_DAY   = 7'd2;
    localparam logic [6:0] RESET_MONTH = 7'd2;
    localparam logic [6:0] RESET_YEAR  = 7'd24;

    localparam logic [4:0] MONTH_LEN [12] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    // Returns 0 for an out-of-range month so any day compare fails.
    function automatic logic [4:0] days_in_month(input logic [6:0] month,
                                                 input logic [6:0] year);
        logic [4:0] len;
        logic [3:0] idx;
        len = 5'd0;
        idx = 4'(month - 7'd1);
        if (month >= 7'd1 && month <= 7'd12) begin
            len = MONTH_LEN[idx];
        end
        if (month == 7'd2 && year[1:0] == 2'b00) begin
            len = 5'd29;
        end
        return len;
    endfunction

endpackage

// File: rtl/calendar_set_ctrl_if.sv
// UART frame handshake plus calendar-side control bundle of calendar_set_ctrl.
// Handshake: a frame transfers on a cycle where uart_valid and uart_ready are both high; valid without ready is dropped, never held.
interface calendar_set_ctrl_if;
    logic       uart_valid;
    logic [6:0] uart_day;
    logic [6:0] uart_month;
    logic [6:0] uart_year;
    logic       uart_ready;
    logic       uart_err;

    logic       set;
    logic       less_inc;
    logic       middle_inc;
    logic       big_inc;
    logic       uart_sign;
    logic [6:0] less_uart;
    logic [6:0] middle_uart;
    logic [6:0] big_uart;
    logic [1:0] field_sel;

    modport master (
        output uart_valid, uart_day, uart_month, uart_year,
        input  uart_ready, uart_err, set, less_inc, middle_inc, big_inc,
        input  uart_sign, less_uart, middle_uart, big_uart, field_sel
    );

    modport slave (
        input  uart_valid, uart_day, uart_month, uart_year,
        output uart_ready, uart_err, set, less_inc, middle_inc, big_inc,
        output uart_sign, less_uart, middle_uart, big_uart, field_sel
    );
endinterface

// File: rtl/calendar_set_ctrl_edge_sync.sv
// Multi-flop synchronizer for an asynchronous button level followed by a
// rising-edge detector; rise_o is high for one cycle per synchronized rise.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/calendar_set_ctrl.sv
// Sequences calendar set/increment/load controls from panel buttons and UART frames.
// Define DATE_CHECK_EN to validate UART dates before loading (else loaded unchecked).
module calendar_set_ctrl
    import calendar_ctrl_pkg::*;
#(
    parameter int TIMEOUT_S   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_1hz,
    input  logic                btn_mode,
    input  logic                btn_inc,
    calendar_set_ctrl_if.slave  bus,
    output ctrl_state_e         state_dbg_o
);
    localparam logic [5:0] TIMEOUT_LIM = 6'(TIMEOUT_S);

    ctrl_state_e state_q, state_d;
    logic [5:0]  tmo_q, tmo_d;
    logic        set_q, set_d;
    logic        sign_q, sign_d;
    logic        less_q, less_d;
    logic        mid_q, mid_d;
    logic        big_q, big_d;
    logic        err_q, err_d;
    logic [1:0]  fsel_q, fsel_d;
    logic [6:0]  day_q, day_d;
    logic [6:0]  mon_q, mon_d;
    logic [6:0]  yr_q, yr_d;

    logic mode_e;
    logic inc_e;
    logic accept;
    logic frame_ok;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mode_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (btn_mode),
        .rise_o  (mode_e)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_inc_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (btn_inc),
        .rise_o  (inc_e)
    );

    assign accept = bus.uart_valid && (state_q != ST_LOAD);

`ifdef DATE_CHECK_EN
    assign frame_ok = (bus.uart_month >= 7'd1) && (bus.uart_month <= 7'd12) &&
                      (bus.uart_day >= 7'd1) &&
                      (bus.uart_day <= {2'b00, days_in_month(bus.uart_month, bus.uart_year)}) &&
                      (bus.uart_year <= 7'd99);
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            tmo_q   <= 6'd0;
            set_q   <= 1'b0;
            sign_q  <= 1'b0;
            less_q  <= 1'b0;
            mid_q   <= 1'b0;
            big_q   <= 1'b0;
            err_q   <= 1'b0;
            fsel_q  <= FIELD_NONE;
            day_q   <= RESET_DAY;
            mon_q   <= RESET_MONTH;
            yr_q    <= RESET_YEAR;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            set_q   <= set_d;
            sign_q  <= sign_d;
            less_q  <= less_d;
            mid_q   <= mid_d;
            big_q   <= big_d;
            err_q   <= err_d;
            fsel_q  <= fsel_d;
            day_q   <= day_d;
            mon_q   <= mon_d;
            yr_q    <= yr_d;
        end
    end

    // Priority: UART accept, then mode edge, then inc edge, then timeout tick.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        less_d  = 1'b0;
        mid_d   = 1'b0;
        big_d   = 1'b0;
        err_d   = 1'b0;
        day_d   = day_q;
        mon_d   = mon_q;
        yr_d    = yr_q;

        if (accept) begin
            if (frame_ok) begin
                state_d = ST_LOAD;
                tmo_d   = 6'd0;
                day_d   = bus.uart_day;
                mon_d   = bus.uart_month;
                yr_d    = bus.uart_year;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    tmo_d = 6'd0;
                    if (mode_e) begin
                        state_d = ST_EDIT_DAY;
                    end
                end
                ST_EDIT_DAY, ST_EDIT_MONTH, ST_EDIT_YEAR: begin
                    if (mode_e) begin
                        tmo_d = 6'd0;
                        case (state_q)
                            ST_EDIT_DAY:   state_d = ST_EDIT_MONTH;
                            ST_EDIT_MONTH: state_d = ST_EDIT_YEAR;
                            default:       state_d = ST_RUN;
                        endcase
                    end else if (inc_e) begin
                        tmo_d  = 6'd0;
                        less_d = (state_q == ST_EDIT_DAY);
                        mid_d  = (state_q == ST_EDIT_MONTH);
                        big_d  = (state_q == ST_EDIT_YEAR);
                    end else if (tick_1hz) begin
                        if (tmo_q + 6'd1 >= TIMEOUT_LIM) begin
                            state_d = ST_RUN;
                            tmo_d   = 6'd0;
                        end else begin
                            tmo_d = tmo_q + 6'd1;
                        end
                    end
                end
                ST_LOAD: begin
                    state_d = ST_RUN;
                    tmo_d   = 6'd0;
                end
                default: begin
                    state_d = ST_RUN;
                    tmo_d   = 6'd0;
                end
            endcase
        end

        set_d  = (state_d != ST_RUN);
        sign_d = (state_d == ST_LOAD);
        case (state_d)
            ST_EDIT_DAY:   fsel_d = FIELD_DAY;
            ST_EDIT_MONTH: fsel_d = FIELD_MONTH;
            ST_EDIT_YEAR:  fsel_d = FIELD_YEAR;
            default:       fsel_d = FIELD_NONE;
        endcase
    end

    assign bus.uart_ready  = (state_q != ST_LOAD);
    assign bus.uart_err    = err_q;
    assign bus.set         = set_q;
    assign bus.uart_sign   = sign_q;
    assign bus.less_inc    = less_q;
    assign bus.middle_inc  = mid_q;
    assign bus.big_inc     = big_q;
    assign bus.field_sel   = fsel_q;
    assign bus.less_uart   = day_q;
    assign bus.middle_uart = mon_q;
    assign bus.big_uart    = yr_q;
    assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Self-checking bench for calendar_set_ctrl against a date/field reference model.
// Builds with or without DATE_CHECK_EN; the expected frame rule follows the macro.
module tb_calendar_set_ctrl;
    import calendar_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        tick_1hz;
    logic        btn_mode;
    logic        btn_inc;
    ctrl_state_e state_dbg;

    calendar_set_ctrl_if bus ();

    calendar_set_ctrl #(.TIMEOUT_S(10), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model: selected field (0 none, 1 day, 2 month, 3 year) and held date.
    int         field;
    logic [20:0] hold;
    logic [20:0] exp_q[$];

    // Pulse monitor
    int   n_less, n_mid, n_big, n_multi, n_long, n_err;
    logic p_less, p_mid, p_big;
    initial begin
        n_less = 0; n_mid = 0; n_big = 0; n_multi = 0; n_long = 0; n_err = 0;
        p_less = 1'b0; p_mid = 1'b0; p_big = 1'b0;
    end
    always @(negedge clk) begin
        if (bus.less_inc === 1'b1) n_less++;
        if (bus.middle_inc === 1'b1) n_mid++;
        if (bus.big_inc === 1'b1) n_big++;
        if (bus.uart_err === 1'b1) n_err++;
        if (int'(bus.less_inc) + int'(bus.middle_inc) + int'(bus.big_inc) > 1) n_multi++;
        if ((bus.less_inc && p_less) || (bus.middle_inc && p_mid) || (bus.big_inc && p_big)) n_long++;
        p_less = bus.less_inc;
        p_mid  = bus.middle_inc;
        p_big  = bus.big_inc;
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        cycles(4);
        btn_mode = 1'b0;
        cycles(4);
        field = (field + 1) % 4;
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        cycles(4);
        btn_inc = 1'b0;
        cycles(4);
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        cycle();
        tick_1hz = 1'b0;
        cycle();
    endtask

    task automatic goto_field(input int f);
        while (field != f) press_mode();
    endtask

`ifdef DATE_CHECK_EN
    function automatic bit tb_date_ok(input int d, input int m, input int y);
        int len;
        if (m < 1 || m > 12) return 1'b0;
        if (m == 2) len = (y % 4 == 0) ? 29 : 28;
        else if (m == 4 || m == 6 || m == 9 || m == 11) len = 30;
        else len = 31;
        return (d >= 1) && (d <= len) && (y <= 99);
    endfunction
`endif

    // Sends one frame (accepted because the FSM is not in LOAD) and checks the outcome.
    task automatic send_and_check(input int d, input int m, input int y);
        bit          ok;
        logic [20:0] exp;
        logic [20:0] got;
`ifdef DATE_CHECK_EN
        ok = tb_date_ok(d, m, y);
`else
        ok = 1'b1;
`endif
        bus.uart_day   = 7'(d);
        bus.uart_month = 7'(m);
        bus.uart_year  = 7'(y);
        bus.uart_valid = 1'b1;
        cycle();
        bus.uart_valid = 1'b0;
        got = {bus.less_uart, bus.middle_uart, bus.big_uart};
        if (ok) begin
            exp_q.push_back({7'(d), 7'(m), 7'(y)});
            checks++;
            if (bus.set !== 1'b1 || bus.uart_sign !== 1'b1 || state_dbg !== ST_LOAD ||
                bus.uart_ready !== 1'b0 || bus.field_sel !== 2'd0)
                begin failures++; $display("FAIL load_ctl %0d/%0d/%0d: set=%b sign=%b st=%0d rdy=%b fs=%0d, want 1 1 %0d 0 0",
                                           d, m, y, bus.set, bus.uart_sign, state_dbg, bus.uart_ready, bus.field_sel, ST_LOAD); end
            exp  = exp_q.pop_front();
            hold = exp;
            checks++;
            if (got !== exp)
                begin failures++; $display("FAIL load_val: got %0d/%0d/%0d want %0d/%0d/%0d",
                                           got[20:14], got[13:7], got[6:0], exp[20:14], exp[13:7], exp[6:0]); end
            cycle();
            field = 0;
            checks++;
            if (state_dbg !== ST_RUN || bus.set !== 1'b0 || bus.uart_sign !== 1'b0 || bus.uart_ready !== 1'b1)
                begin failures++; $display("FAIL load_exit: st=%0d set=%b sign=%b rdy=%b, want RUN 0 0 1",
                                           state_dbg, bus.set, bus.uart_sign, bus.uart_ready); end
        end else begin
            checks++;
            if (bus.uart_err !== 1'b1 || got !== hold || bus.uart_sign !== 1'b0)
                begin failures++; $display("FAIL reject %0d/%0d/%0d: err=%b sign=%b vals=%h, want err=1 sign=0 vals=%h",
                                           d, m, y, bus.uart_err, bus.uart_sign, got, hold); end
            checks++;
            if (bus.field_sel !== 2'(field) || bus.set !== (field != 0))
                begin failures++; $display("FAIL reject_state: fs=%0d set=%b, want fs=%0d set=%b",
                                           bus.field_sel, bus.set, field, field != 0); end
            cycle();
            checks++;
            if (bus.uart_err !== 1'b0)
                begin failures++; $display("FAIL err_pulse: uart_err=%b one cycle later, want 0", bus.uart_err); end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        cycles(3);
        checks++;
        if (state_dbg !== ST_RUN || bus.set !== 1'b0 || bus.uart_ready !== 1'b1 || bus.uart_err !== 1'b0)
            begin failures++; $display("FAIL in_reset: st=%0d set=%b rdy=%b err=%b", state_dbg, bus.set, bus.uart_ready, bus.uart_err); end
        reset = 1'b1;
        cycles(2);
        field = 0;
        hold  = {7'd2, 7'd2, 7'd24};
        checks++;
        if (state_dbg !== ST_RUN || bus.set !== 1'b0 || bus.uart_sign !== 1'b0 || bus.field_sel !== 2'd0 ||
            bus.less_inc !== 1'b0 || bus.middle_inc !== 1'b0 || bus.big_inc !== 1'b0 || bus.uart_ready !== 1'b1)
            begin failures++; $display("FAIL reset_ctl: st=%0d set=%b sign=%b fs=%0d rdy=%b",
                                       state_dbg, bus.set, bus.uart_sign, bus.field_sel, bus.uart_ready); end
        checks++;
        if ({bus.less_uart, bus.middle_uart, bus.big_uart} !== hold)
            begin failures++; $display("FAIL reset_date: got %0d/%0d/%0d want 2/2/24",
                                       bus.less_uart, bus.middle_uart, bus.big_uart); end
    endtask

    task automatic test_field_cycle();
        int l0, m0, b0, el, em, eb;
        for (int i = 0; i < 4; i++) begin
            press_mode();
            checks++;
            if (bus.field_sel !== 2'(field) || bus.set !== (field != 0))
                begin failures++; $display("FAIL field_cycle[%0d]: fs=%0d set=%b want fs=%0d set=%b",
                                           i, bus.field_sel, bus.set, field, field != 0); end
        end
        goto_field(2);
        l0 = n_less; m0 = n_mid; b0 = n_big;
        repeat (3) press_inc();
        checks++;
        if (n_mid - m0 !== 3 || n_less !== l0 || n_big !== b0)
            begin failures++; $display("FAIL month_inc: mid=%0d less=%0d big=%0d want 3 0 0",
                                       n_mid - m0, n_less - l0, n_big - b0); end
        // random mode/inc mix, including presses in RUN that must be ignored
        l0 = n_less; m0 = n_mid; b0 = n_big; el = 0; em = 0; eb = 0;
        repeat (12) begin
            if ($urandom_range(0, 2) == 0) press_mode();
            else begin
                press_inc();
                if (field == 1) el++;
                else if (field == 2) em++;
                else if (field == 3) eb++;
            end
        end
        checks++;
        if (n_less - l0 !== el || n_mid - m0 !== em || n_big - b0 !== eb)
            begin failures++; $display("FAIL rand_inc: got %0d/%0d/%0d want %0d/%0d/%0d",
                                       n_less - l0, n_mid - m0, n_big - b0, el, em, eb); end
        checks++;
        if (n_multi !== 0 || n_long !== 0)
            begin failures++; $display("FAIL pulse_shape: multi=%0d long=%0d want 0 0", n_multi, n_long); end
        goto_field(0);
    endtask

    task automatic test_timeout();
        int l0, k;
        goto_field(1);
        repeat (9) tick();
        checks++;
        if (bus.field_sel !== 2'd1)
            begin failures++; $display("FAIL tmo_9: fs=%0d want 1", bus.field_sel); end
        tick();
        field = 0;
        checks++;
        if (bus.field_sel !== 2'd0 || bus.set !== 1'b0 || state_dbg !== ST_RUN)
            begin failures++; $display("FAIL tmo_10: fs=%0d set=%b want 0 0", bus.field_sel, bus.set); end
        // inc press after a random number of ticks restarts the count
        k = $urandom_range(1, 9);
        goto_field(1);
        l0 = n_less;
        repeat (k) tick();
        press_inc();
        repeat (9) tick();
        checks++;
        if (bus.field_sel !== 2'd1 || n_less - l0 !== 1)
            begin failures++; $display("FAIL tmo_restart(k=%0d): fs=%0d incs=%0d want 1 1", k, bus.field_sel, n_less - l0); end
        tick();
        field = 0;
        checks++;
        if (bus.field_sel !== 2'd0 || bus.set !== 1'b0)
            begin failures++; $display("FAIL tmo_restart_end: fs=%0d set=%b want 0 0", bus.field_sel, bus.set); end
        // inc edge lands in the same cycle as the 10th tick: counter clears, no timeout
        goto_field(1);
        l0 = n_less;
        repeat (9) tick();
        btn_inc = 1'b1;
        cycles(2);
        tick_1hz = 1'b1;
        cycle();
        tick_1hz = 1'b0;
        cycles(2);
        btn_inc = 1'b0;
        cycles(4);
        checks++;
        if (bus.field_sel !== 2'd1 || n_less - l0 !== 1)
            begin failures++; $display("FAIL tick_edge: fs=%0d incs=%0d want 1 1", bus.field_sel, n_less - l0); end
        repeat (9) tick();
        checks++;
        if (bus.field_sel !== 2'd1)
            begin failures++; $display("FAIL tick_edge_9: fs=%0d want 1", bus.field_sel); end
        tick();
        field = 0;
        checks++;
        if (bus.field_sel !== 2'd0)
            begin failures++; $display("FAIL tick_edge_10: fs=%0d want 0", bus.field_sel); end
    endtask

    task automatic test_uart_load();
        logic [20:0] got;
        goto_field(3);
        send_and_check(15, 8, 25);
        // mode edge coincident with the accepted frame is lost
        btn_mode = 1'b1;
        cycles(2);
        bus.uart_day = 7'd10; bus.uart_month = 7'd3; bus.uart_year = 7'd30;
        bus.uart_valid = 1'b1;
        cycle();
        bus.uart_valid = 1'b0;
        hold = {7'd10, 7'd3, 7'd30};
        checks++;
        if (state_dbg !== ST_LOAD)
            begin failures++; $display("FAIL mode_coinc_load: st=%0d want %0d", state_dbg, ST_LOAD); end
        cycles(2);
        btn_mode = 1'b0;
        cycles(4);
        field = 0;
        checks++;
        if (bus.field_sel !== 2'd0 || state_dbg !== ST_RUN)
            begin failures++; $display("FAIL mode_coinc_drop: fs=%0d st=%0d want 0 RUN", bus.field_sel, state_dbg); end
        // back-to-back valid: the second frame lands in LOAD and is dropped
        bus.uart_day = 7'd5; bus.uart_month = 7'd6; bus.uart_year = 7'd7;
        bus.uart_valid = 1'b1;
        cycle();
        bus.uart_day = 7'd20; bus.uart_month = 7'd11; bus.uart_year = 7'd50;
        cycle();
        bus.uart_valid = 1'b0;
        hold = {7'd5, 7'd6, 7'd7};
        cycle();
        got = {bus.less_uart, bus.middle_uart, bus.big_uart};
        checks++;
        if (got !== hold || state_dbg !== ST_RUN || bus.uart_sign !== 1'b0)
            begin failures++; $display("FAIL load_drop: vals=%0d/%0d/%0d st=%0d want 5/6/7 RUN",
                                       got[20:14], got[13:7], got[6:0], state_dbg); end
        // random valid frames from random fields
        repeat (6) begin
            goto_field($urandom_range(0, 3));
            cycles($urandom_range(0, 2));
            send_and_check($urandom_range(1, 28), $urandom_range(1, 12), $urandom_range(0, 99));
        end
    endtask

    task automatic test_date_check();
`ifdef DATE_CHECK_EN
        send_and_check(29, 2, 24);
        send_and_check(29, 2, 23);
        goto_field(1);
        send_and_check(31, 4, 24);
        send_and_check(0, 13, 24);
        repeat (10) send_and_check($urandom_range(0, 31), $urandom_range(0, 13), $urandom_range(0, 127));
        goto_field(0);
`else
        send_and_check(29, 2, 23);
        send_and_check(0, 13, 24);
        checks++;
        if (n_err !== 0)
            begin failures++; $display("FAIL err_tied: %0d uart_err pulses, want 0", n_err); end
`endif
    endtask

    task automatic test_reset_mid_edit();
        int l0;
        goto_field(1);
        l0 = n_less;
        btn_inc = 1'b1;
        cycles(2);
        #2 reset = 1'b0;
        cycle();
        checks++;
        if (state_dbg !== ST_RUN || bus.set !== 1'b0 || bus.less_inc !== 1'b0 || n_less !== l0)
            begin failures++; $display("FAIL rst_mid: st=%0d set=%b incs=%0d want RUN 0 0", state_dbg, bus.set, n_less - l0); end
        cycle();
        reset = 1'b1;
        field = 0;
        hold  = {7'd2, 7'd2, 7'd24};
        cycles(6);
        btn_inc = 1'b0;
        cycles(2);
        checks++;
        if (n_less !== l0 || bus.field_sel !== 2'd0 || {bus.less_uart, bus.middle_uart, bus.big_uart} !== hold)
            begin failures++; $display("FAIL rst_release: incs=%0d fs=%0d vals=%0d/%0d/%0d want 0 0 2/2/24",
                                       n_less - l0, bus.field_sel, bus.less_uart, bus.middle_uart, bus.big_uart); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        bus.uart_valid = 1'b0; bus.uart_day = '0; bus.uart_month = '0; bus.uart_year = '0;
        field = 0;
        hold  = {7'd2, 7'd2, 7'd24};
        test_reset();
        test_field_cycle();
        test_timeout();
        test_uart_load();
        test_date_check();
        test_reset_mid_edit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
